wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and general-purpose register file of the 5-stage pipeline. It takes the outputs of the MEM/WB pipeline register and selects the write-back value (memory data or ALU result). It commits that value into a 32-entry GPR array and serves the two decode-stage read ports, with same-cycle write-to-read bypass. It also exposes the write-back value for the forwarding network and keeps a count of committed register writes.

## Interface
Parameters:
- DW, 32, data width of registers and buses
- AW, 5, register address width; the array holds 2^AW entries
- CW, 32, width of the write-commit counter

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- wwreg  in  1  write-back register-write enable from MEM/WB
- wm2reg  in  1  1 selects memory data wmo, 0 selects ALU result walu
- wmo  in  DW  memory read data from MEM/WB
- walu  in  DW  ALU result from MEM/WB
- wGPR  in  AW  destination register number from MEM/WB
- rna  in  AW  read port A address (decode stage rs)
- rnb  in  AW  read port B address (decode stage rt)
- qa  out  DW  read port A data
- qb  out  DW  read port B data
- wdata  out  DW  selected write-back value, for forwarding
- wcnt  out  CW  number of committed writes since reset

## Operation
- Write-back mux: wdata = wm2reg ? wmo : walu. This path is purely combinational and is valid whether or not wwreg is set.
- Commit condition: we = wwreg && (wGPR != 0). On a rising clk edge with we=1, regs[wGPR] <= wdata.
- Register 0 is hardwired to zero. A write to register 0 is discarded, and reads of register 0 return 0 in every case, including during reset.
- Read ports are combinational. qa = (rna==0) ? 0 : (we && rna==wGPR) ? wdata : regs[rna]. qb is computed the same way from rnb.
- The bypass makes a value being written in cycle N visible on qa/qb in cycle N, before the clock edge. Decode therefore never sees a stale value from write-back.
- wcnt increments by 1 on every rising edge with we=1. It wraps modulo 2^CW from all-ones back to 0 without saturating. Writes to register 0 and cycles with wwreg=0 leave it unchanged.
- No stall or handshake input. Every cycle's MEM/WB contents are consumed, and a bubble (wwreg=0) is a no-op.

## Timing
- Reset: while rst=1 at a rising edge, all regs[1..2^AW-1] <= 0 and wcnt <= 0. A write presented in the same cycle as reset is dropped, because reset has priority over commit.
- After reset: qa=qb=0 for every address, wcnt=0, and wdata follows the inputs combinationally.
- Reset asserted mid-stream clears the array and counter on that edge. The first write after reset deassertion commits on the next edge.
- Write latency: the array is updated on the edge that ends the cycle in which we=1. Bypass gives zero-cycle read-after-write visibility. Read-after-write in later cycles comes from the array.
- Two ports reading the same address return identical data. A simultaneous read on both ports of the address being written returns wdata on both.
- wm2reg and wmo are ignored for commit when wwreg=0. Changing them has no effect on the array or on wcnt.

## Test plan
- Reset then read: assert rst for 2 cycles, release, and sweep rna/rnb over 0..31 -> qa=qb=0 for all addresses and wcnt=0.
- ALU vs memory select, with registers starting at 0: cycle 1 wwreg=1, wm2reg=0, walu=0x12345678, wmo=0xDEADBEEF, wGPR=5. Cycle 2 wm2reg=1, wGPR=6. Then read rna=5, rnb=6 -> qa=0x12345678, qb=0xDEADBEEF, wcnt=2.
- Bypass: in the same cycle, wwreg=1, wGPR=9, walu=0xA5A5A5A5, rna=rnb=9 -> qa=qb=0xA5A5A5A5 before the edge. After the edge, with wwreg=0, qa is still 0xA5A5A5A5.
- Register 0 protection: wwreg=1, wGPR=0, walu=0xFFFFFFFF, rna=0 -> qa=0 during and after the edge, and wcnt is unchanged.
- Bubble and reset priority: wwreg=0, wGPR=3, walu=7 -> reg3 stays 0. Then wwreg=1, wGPR=3, walu=7 together with rst=1 for one edge -> after release reg3=0 and wcnt=0.
- Counter wrap: with CW=4, perform 17 writes to register 1 with walu=i -> wcnt=1 and reg1=16.

Source files
------------

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, decode read ports and
// forwarding/commit-count outputs.
interface wb_regfile_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 32
);
    logic          wwreg;
    logic          wm2reg;
    logic [DW-1:0] wmo;
    logic [DW-1:0] walu;
    logic [AW-1:0] wGPR;
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] wdata;
    logic [CW-1:0] wcnt;

    modport master (
        output wwreg, wm2reg, wmo, walu, wGPR, rna, rnb,
        input  qa, qb, wdata, wcnt
    );

    modport slave (
        input  wwreg, wm2reg, wmo, walu, wGPR, rna, rnb,
        output qa, qb, wdata, wcnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage mux plus 2^AW-entry GPR file with two bypassed read ports
// and a count of committed register writes.
module wb_regfile #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_regfile_if.slave bus
);
    localparam int unsigned NREG = 1 << AW;

    logic [DW-1:0] regs_q [NREG];
    logic [CW-1:0] wcnt_q;
    logic [DW-1:0] wdata;
    logic          we;

    always_comb begin
        wdata = bus.wm2reg ? bus.wmo : bus.walu;
        we    = bus.wwreg && (bus.wGPR != '0);
    end

    // Reset wins over a commit presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wcnt_q <= '0;
        end else if (we) begin
            regs_q[bus.wGPR] <= wdata;
            wcnt_q           <= wcnt_q + CW'(1);
        end
    end

    // Same-cycle bypass so decode never sees a value write-back is about to replace.
    always_comb begin
        bus.qa = '0;
        bus.qb = '0;
        if (bus.rna != '0) begin
            bus.qa = (we && bus.rna == bus.wGPR) ? wdata : regs_q[bus.rna];
        end
        if (bus.rnb != '0) begin
            bus.qb = (we && bus.rnb == bus.wGPR) ? wdata : regs_q[bus.rnb];
        end
        bus.wdata = wdata;
        bus.wcnt  = wcnt_q;
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for write-back/bypass/reset
// behaviour, plus a hand-written counter-wrap sequence on a CW=4 instance.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    wb_regfile_if #(.DW(32), .AW(5), .CW(32)) b1 ();
    wb_regfile_if #(.DW(32), .AW(5), .CW(4))  b2 ();

    wb_regfile #(.DW(32), .AW(5), .CW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    wb_regfile #(.DW(32), .AW(5), .CW(4)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        wwreg;
        logic        wm2reg;
        logic [31:0] wmo;
        logic [31:0] walu;
        logic [4:0]  wgpr;
        logic [4:0]  rna;
        logic [4:0]  rnb;
        logic [31:0] exp_qa;
        logic [31:0] exp_qb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wcnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Inputs are checked mid-cycle (before the committing edge).
        vecs[0]  = '{"alu_sel",   0, 1, 0, 32'hDEADBEEF, 32'h12345678, 5, 5, 6,
                     32'h12345678, 32'h0,        32'h12345678, 0};
        vecs[1]  = '{"mem_sel",   0, 1, 1, 32'hDEADBEEF, 32'h12345678, 6, 5, 6,
                     32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[2]  = '{"sel_read",  0, 0, 1, 32'h11111111, 32'h12345678, 6, 5, 6,
                     32'h12345678, 32'hDEADBEEF, 32'h11111111, 2};
        vecs[3]  = '{"bypass",    0, 1, 0, 32'h0,        32'hA5A5A5A5, 9, 9, 9,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 2};
        vecs[4]  = '{"post_byp",  0, 0, 0, 32'h0,        32'h0,        9, 9, 9,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        3};
        vecs[5]  = '{"r0_write",  0, 1, 0, 32'h0,        32'hFFFFFFFF, 0, 0, 9,
                     32'h0,        32'hA5A5A5A5, 32'hFFFFFFFF, 3};
        vecs[6]  = '{"r0_after",  0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 0, 0,
                     32'h0,        32'h0,        32'hFFFFFFFF, 3};
        vecs[7]  = '{"bubble",    0, 0, 0, 32'h0,        32'h7,        3, 3, 5,
                     32'h0,        32'h12345678, 32'h7,        3};
        vecs[8]  = '{"bub_mem",   0, 0, 1, 32'h99,       32'h7,        3, 3, 3,
                     32'h0,        32'h0,        32'h99,       3};
        vecs[9]  = '{"rst_wr",    1, 1, 0, 32'h0,        32'h7,        3, 3, 0,
                     32'h7,        32'h0,        32'h7,        3};
        vecs[10] = '{"post_rst",  0, 0, 0, 32'h0,        32'h7,        3, 3, 5,
                     32'h0,        32'h0,        32'h7,        0};
        vecs[11] = '{"first_wr",  0, 1, 0, 32'h0,        32'h42,       3, 3, 9,
                     32'h42,       32'h0,        32'h42,       0};
        vecs[12] = '{"first_rd",  0, 0, 0, 32'h0,        32'h42,       3, 3, 9,
                     32'h42,       32'h0,        32'h42,       1};

        {b1.wwreg, b1.wm2reg, b1.wmo, b1.walu, b1.wGPR, b1.rna, b1.rnb} = '0;
        {b2.wwreg, b2.wm2reg, b2.wmo, b2.walu, b2.wGPR, b2.rna, b2.rnb} = '0;

        // Two reset cycles, then sweep every address on both ports.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            b1.rna = 5'(a);
            b1.rnb = 5'(31 - a);
            #1;
            chk($sformatf("rst_qa[%0d]", a), b1.qa, 32'h0);
            chk($sformatf("rst_qb[%0d]", 31 - a), b1.qb, 32'h0);
        end
        chk("rst_wcnt", b1.wcnt, 32'h0);

        for (int i = 0; i < 13; i++) begin
            rst       = vecs[i].rst;
            b1.wwreg  = vecs[i].wwreg;
            b1.wm2reg = vecs[i].wm2reg;
            b1.wmo    = vecs[i].wmo;
            b1.walu   = vecs[i].walu;
            b1.wGPR   = vecs[i].wgpr;
            b1.rna    = vecs[i].rna;
            b1.rnb    = vecs[i].rnb;
            @(negedge clk);
            chk({vecs[i].name, ".qa"},    b1.qa,    vecs[i].exp_qa);
            chk({vecs[i].name, ".qb"},    b1.qb,    vecs[i].exp_qb);
            chk({vecs[i].name, ".wdata"}, b1.wdata, vecs[i].exp_wdata);
            chk({vecs[i].name, ".wcnt"},  b1.wcnt,  vecs[i].exp_wcnt);
            @(posedge clk);
            #1;
        end
        b1.wwreg = 1'b0;

        // Counter wrap on the CW=4 instance: 17 writes to r1 with walu=i.
        for (int i = 0; i <= 16; i++) begin
            b2.wwreg = 1'b1;
            b2.wGPR  = 5'd1;
            b2.walu  = 32'(i);
            @(posedge clk);
            #1;
            if (i == 15) begin
                chk("wrap_cnt16", 32'(b2.wcnt), 32'h0);
            end
        end
        b2.wwreg = 1'b0;
        b2.rna   = 5'd1;
        b2.rnb   = 5'd1;
        #1;
        chk("wrap_cnt17", 32'(b2.wcnt), 32'h1);
        chk("wrap_r1_qa", b2.qa, 32'd16);
        chk("wrap_r1_qb", b2.qb, 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
